custstep_checker: RTL

- Downstream consumer of the +5/−2 alternating custom counter.
- Samples the counter's 8-bit output stream and locks onto the alternating pattern. Once locked, it flags any sample that breaks the pattern.
- Provides a lock indicator, a one-cycle error pulse, a saturating error counter and the predicted next value, for use in bring-up and self-checking benches.

---
 rtl/custcount_pkg.sv | 7 +
 rtl/custstep_classify.sv | 18 +
 rtl/custstep_checker.sv | 90 +++++++++
 3 files changed

// File: rtl/custcount_pkg.sv
// custcount_pkg: shared types and step defaults for +INC/-DEC custom counter monitors.
package custcount_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  typedef enum logic [1:0] {STEP_NONE, STEP_INC, STEP_DEC, STEP_BAD} step_t;
  localparam int DEF_INC = 5;
  localparam int DEF_DEC = 2;
endpackage

// File: rtl/custstep_classify.sv
// custstep_classify: classifies the modular delta between two samples as INC, DEC or BAD.
module custstep_classify
  import custcount_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int INC   = DEF_INC,
  parameter int DEC   = DEF_DEC
) (
  input  logic [WIDTH-1:0] i_prev,
  input  logic [WIDTH-1:0] i_count,
  output step_t            o_step
);
  localparam logic [WIDTH-1:0] L_INC = WIDTH'(INC);
  localparam logic [WIDTH-1:0] L_DEC = ~WIDTH'(DEC) + 1'b1;
  logic [WIDTH-1:0] w_delta;
  assign w_delta = i_count - i_prev;
  assign o_step  = (w_delta == L_INC) ? STEP_INC : (w_delta == L_DEC) ? STEP_DEC : STEP_BAD;
endmodule

// File: rtl/custstep_checker.sv
// custstep_checker: locks onto an alternating +INC/-DEC sample stream and flags breaks once locked.
module custstep_checker
  import custcount_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int INC      = DEF_INC,
  parameter int DEC      = DEF_DEC,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_valid,
  input  logic             i_clr_err,
  output logic             o_locked,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_count,
  output logic [WIDTH-1:0] o_expected
);
  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  state_t           r_state;
  step_t            r_last;
  logic [WIDTH-1:0] r_prev;
  logic [RUN_W-1:0] r_run;
  step_t            w_step;
  logic             w_good;
  logic             w_mismatch;
  logic [RUN_W-1:0] w_run_inc;
  logic [WIDTH-1:0] w_pred;
  logic [ERR_W-1:0] w_cnt_base;
  custstep_classify #(.WIDTH(WIDTH), .INC(INC), .DEC(DEC)) u_classify (
    .i_prev (r_prev),
    .i_count(i_count),
    .o_step (w_step)
  );
  assign w_run_inc  = r_run + 1'b1;
  assign w_good     = (w_step == STEP_INC || w_step == STEP_DEC) && w_step != r_last;
  // The step that produced this sample decides the direction of the next one.
  assign w_pred     = (w_step == STEP_DEC) ? i_count + WIDTH'(INC) : i_count - WIDTH'(DEC);
  assign w_mismatch = i_valid && r_state == LOCKED && i_count != o_expected;
  assign w_cnt_base = i_clr_err ? '0 : o_err_count;
  assign o_locked   = (r_state == LOCKED);
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_last      <= STEP_NONE;
      r_prev      <= '0;
      r_run       <= '0;
      o_err       <= 1'b0;
      o_err_count <= '0;
      o_expected  <= '0;
    end else begin
      o_err       <= w_mismatch;
      o_err_count <= (w_mismatch && !(&w_cnt_base)) ? w_cnt_base + 1'b1 : w_cnt_base;
      if (i_valid) begin
        r_prev <= i_count;
        case (r_state)
          IDLE: begin
            r_state <= ACQUIRE;
            r_run   <= '0;
            r_last  <= STEP_NONE;
          end
          ACQUIRE: begin
            if (w_good) begin
              r_run  <= w_run_inc;
              r_last <= w_step;
              if (w_run_inc == RUN_W'(LOCK_CNT)) begin
                r_state    <= LOCKED;
                o_expected <= w_pred;
              end
            end else begin
              r_run  <= (w_step == STEP_BAD) ? '0 : RUN_W'(1);
              r_last <= (w_step == STEP_BAD) ? STEP_NONE : w_step;
            end
          end
          default: begin
            if (w_mismatch) begin
              r_state <= ACQUIRE;
              r_run   <= '0;
              r_last  <= STEP_NONE;
            end else begin
              o_expected <= w_pred;
            end
          end
        endcase
      end
    end
  end
endmodule
